td4_bus_sequencer: RTL and testbench
====================================

Name: td4_bus_sequencer

Overview:
- Control-side counterpart of the 4-bit register slices (A, B, OUT, PC) in the TTM4 emulator.
- Fetches an 8-bit instruction (opcode[7:4], immediate[3:0]) and decodes it.
- Asserts the active-low register store strobes (nX_ST) and bus output enables (nX_OUT) that the register slices consume.
- Computes the adder result fed back to the registers as STOREDATA, holds the carry flag, and drives PC load/count.

Parameters:
RESET_RUN, 1, 1 = leave reset into FETCH; 0 = leave reset into HALT and wait for STEP.
NOP_ON_INVALID, 1, 1 = undefined opcodes assert no strobes (PC still counts); 0 = undefined opcodes decode as ADD A,Im.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  asynchronous, active-low reset.
RUN  input  1  1 = free-run; 0 = halt after the current instruction.
STEP  input  1  single-step request; rising edge detected internally (synchronous sample).
INSTR  input  8  ROM data at address PC; sampled only in FETCH.
BUSDATA  input  4  shared data bus driven by the enabled source register; 0 when no source is enabled.
STOREDATA  output  4  BUSDATA + IR[3:0], modulo 16; drives register DATAIN.
C_FLAG  output  1  registered carry flag.
nA_ST, nB_ST, nOUT_ST  output  1 each  active-low synchronous load strobes.
nA_OUT, nB_OUT, nIN_OUT  output  1 each  active-low tristate enables onto BUSDATA; at most one low.
nPC_LD  output  1  active-low PC load (jump taken).
PC_EN  output  1  PC count enable.
HALTED  output  1  1 while in HALT.

Behaviour:
- Reset values (while RST = 0):
  - state = FETCH if RESET_RUN = 1, otherwise HALT.
  - IR = 8'h00, C_FLAG = 0, STEP edge-detect register = 0.
  - All n* outputs = 1, PC_EN = 0.
  - HALTED = 1 if state is HALT, otherwise 0.
- States:
  - FETCH: IR <= INSTR; decode registered into the strobe/enable flops; next state = EXEC.
  - EXEC: decoded outputs are valid for exactly this cycle, and the target register loads on the edge that ends EXEC. C_FLAG updates on the same edge. Next state = FETCH if RUN = 1, otherwise HALT.
  - HALT: all n* = 1, PC_EN = 0. A detected STEP rising edge moves to FETCH and performs exactly one instruction before returning to HALT (RUN = 0). If RUN = 1, the next state is FETCH.
- Outside EXEC: all n* = 1 and PC_EN = 0.
- Latency: 2 cycles per instruction; ROM address (PC) is stable across FETCH.
- Decode (opcode: source enable, store strobe):
  - 0000 ADD A,Im: nA_OUT, nA_ST
  - 0001 MOV A,B: nB_OUT, nA_ST
  - 0010 IN A: nIN_OUT, nA_ST
  - 0011 MOV A,Im: none, nA_ST
  - 0100 MOV B,A: nA_OUT, nB_ST
  - 0101 ADD B,Im: nB_OUT, nB_ST
  - 0110 IN B: nIN_OUT, nB_ST
  - 0111 MOV B,Im: none, nB_ST
  - 1001 OUT B: nB_OUT, nOUT_ST
  - 1011 OUT Im: none, nOUT_ST
  - 1110 JNC Im: none; taken when C_FLAG = 0
  - 1111 JMP Im: none; always taken
  - All other opcodes: per NOP_ON_INVALID.
- Jumps:
  - Taken jump: nPC_LD = 0 and PC_EN = 0 in EXEC; the PC loads STOREDATA (= 0 + Im).
  - Not-taken jump, and every non-jump opcode: PC_EN = 1 and nPC_LD = 1.
- Carry:
  - STOREDATA/carry = BUSDATA + IR[3:0], 4-bit sum with carry out.
  - C_FLAG <= carry out at the end of every EXEC, for every opcode including jumps and NOPs. This matches the hardware adder being always live.
  - JNC tests the C_FLAG value from before this EXEC's update.
- Wrap-around: F + 1 gives STOREDATA = 0 and C_FLAG = 1. Successive increments wrap with no saturation.
- Simultaneous events:
  - RUN falling during FETCH: the instruction completes, then HALT.
  - STEP edge while RUN = 1 is ignored.
  - STEP held high yields a single step; another step requires a new rising edge.
- Reset mid-EXEC: all strobes deassert immediately (asynchronous). No register load occurs on subsequent edges while RST = 0.
- Invariants: at most one nX_OUT low; at most one of nA_ST / nB_ST / nOUT_ST / nPC_LD low in any cycle.

Test Plan:
- RESET_RUN = 1, RUN = 1, INSTR = 8'h35 (MOV A,5), BUSDATA = 0:
  - EXEC: nA_ST = 0, STOREDATA = 5, PC_EN = 1, all nX_OUT = 1.
  - After the edge: C_FLAG = 0.
- INSTR = 8'h01 (ADD A,1), BUSDATA = F:
  - EXEC: nA_OUT = 0, nA_ST = 0, STOREDATA = 0.
  - After EXEC: C_FLAG = 1.
- After the previous case, INSTR = 8'hE7 (JNC 7): nPC_LD = 1, PC_EN = 1 (not taken). Repeat with C_FLAG = 0: nPC_LD = 0, PC_EN = 0, STOREDATA = 7.
- RUN = 0, single STEP pulse, INSTR = 8'h9x (OUT B), BUSDATA = A:
  - Exactly one FETCH/EXEC pair: nB_OUT = 0, nOUT_ST = 0, STOREDATA = A.
  - Then HALTED = 1 with no strobes.
  - STEP held high for 10 cycles yields only one instruction.
- Assert RST low during EXEC of 8'h55 (ADD B,5):
  - Same cycle: all n* = 1, PC_EN = 0, C_FLAG = 0, IR = 00.
  - On release: FETCH if RESET_RUN = 1, HALT if RESET_RUN = 0.
- Opcode 1000 with NOP_ON_INVALID = 1: no n* low, PC_EN = 1; C_FLAG still updates from BUSDATA (0) + Im.

Source files
------------

// File: rtl/td4_bus_sequencer.sv
// Control sequencer for the TD4 register slices: fetch/decode of an 8-bit instruction,
// active-low store strobes and bus enables, adder result, carry flag and PC control.
module td4_bus_sequencer #(
  parameter bit RESET_RUN      = 1'b1,
  parameter bit NOP_ON_INVALID = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [7:0] INSTR,
  input  logic [3:0] BUSDATA,
  output logic [3:0] STOREDATA,
  output logic       C_FLAG,
  output logic       nA_ST,
  output logic       nB_ST,
  output logic       nOUT_ST,
  output logic       nA_OUT,
  output logic       nB_OUT,
  output logic       nIN_OUT,
  output logic       nPC_LD,
  output logic       PC_EN,
  output logic       HALTED,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = RESET_RUN ? FETCH : HALT;

  // Active-high internal view of the control word; the pins are the inverse.
  typedef struct packed {
    logic a_st;
    logic b_st;
    logic out_st;
    logic a_out;
    logic b_out;
    logic in_out;
    logic pc_ld;
    logic pc_en;
  } ctl_t;

  state_t     state, state_next;
  logic [3:0] ir_imm;
  logic       step_q;
  logic       step_rise;
  ctl_t       ctl, dec;
  logic [4:0] sum;

  assign step_rise = STEP & ~step_q;
  assign sum       = {1'b0, BUSDATA} + {1'b0, ir_imm};
  assign STOREDATA = sum[3:0];

  // Decode straight from the ROM word so the control flops are valid for all of EXEC.
  // JNC looks at the carry before this instruction's own EXEC update.
  always_comb begin
    dec = '0;
    case (INSTR[7:4])
      4'h0: begin dec.a_out  = 1'b1; dec.a_st   = 1'b1; end
      4'h1: begin dec.b_out  = 1'b1; dec.a_st   = 1'b1; end
      4'h2: begin dec.in_out = 1'b1; dec.a_st   = 1'b1; end
      4'h3: dec.a_st = 1'b1;
      4'h4: begin dec.a_out  = 1'b1; dec.b_st   = 1'b1; end
      4'h5: begin dec.b_out  = 1'b1; dec.b_st   = 1'b1; end
      4'h6: begin dec.in_out = 1'b1; dec.b_st   = 1'b1; end
      4'h7: dec.b_st = 1'b1;
      4'h9: begin dec.b_out  = 1'b1; dec.out_st = 1'b1; end
      4'hB: dec.out_st = 1'b1;
      4'hE: dec.pc_ld = ~C_FLAG;
      4'hF: dec.pc_ld = 1'b1;
      default: begin
        if (!NOP_ON_INVALID) begin
          dec.a_out = 1'b1;
          dec.a_st  = 1'b1;
        end
      end
    endcase
    dec.pc_en = ~dec.pc_ld;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= RESET_STATE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = EXEC;
      EXEC:    state_next = RUN ? FETCH : HALT;
      HALT:    if (RUN || step_rise) state_next = FETCH;
      default: state_next = RESET_STATE;
    endcase
  end

  // The control word is live only in EXEC; the adder carry is captured on every EXEC exit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir_imm <= 4'h0;
      C_FLAG <= 1'b0;
      step_q <= 1'b0;
      ctl    <= '0;
    end else begin
      step_q <= STEP;
      if (state == FETCH) begin
        ir_imm <= INSTR[3:0];
        ctl    <= dec;
      end else begin
        ctl    <= '0;
      end
      if (state == EXEC) C_FLAG <= sum[4];
    end
  end

  assign nA_ST     = ~ctl.a_st;
  assign nB_ST     = ~ctl.b_st;
  assign nOUT_ST   = ~ctl.out_st;
  assign nA_OUT    = ~ctl.a_out;
  assign nB_OUT    = ~ctl.b_out;
  assign nIN_OUT   = ~ctl.in_out;
  assign nPC_LD    = ~ctl.pc_ld;
  assign PC_EN     = ctl.pc_en;
  assign HALTED    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_td4_bus_sequencer.sv
// Directed bench for td4_bus_sequencer: run mode, carry/wrap, jumps, invalid opcode,
// single-step, and asynchronous reset during EXEC.
module tb_td4_bus_sequencer;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  // {nA_ST, nB_ST, nOUT_ST, nA_OUT, nB_OUT, nIN_OUT, nPC_LD}
  localparam logic [6:0] V_IDLE  = 7'h7F;
  localparam logic [6:0] V_MOVA  = 7'h3F;
  localparam logic [6:0] V_ADDA  = 7'h37;
  localparam logic [6:0] V_JMP   = 7'h7E;
  localparam logic [6:0] V_OUTB  = 7'h6B;
  localparam logic [6:0] V_ADDB  = 7'h5B;

  logic       CLK, RST, RUN, STEP;
  logic [7:0] INSTR;
  logic [3:0] BUSDATA;

  logic [3:0] STOREDATA, h_storedata;
  logic       C_FLAG, h_c_flag;
  logic       nA_ST, nB_ST, nOUT_ST, nA_OUT, nB_OUT, nIN_OUT, nPC_LD, PC_EN, HALTED;
  logic       h_a_st, h_b_st, h_out_st, h_a_out, h_b_out, h_in_out, h_pc_ld, h_pc_en, h_halted;
  logic [1:0] state_dbg, h_state;

  logic [6:0] nvec, h_nvec;
  assign nvec   = {nA_ST, nB_ST, nOUT_ST, nA_OUT, nB_OUT, nIN_OUT, nPC_LD};
  assign h_nvec = {h_a_st, h_b_st, h_out_st, h_a_out, h_b_out, h_in_out, h_pc_ld};

  int tests  = 0;
  int failed = 0;
  int n_bad;

  td4_bus_sequencer #(.RESET_RUN(1'b1), .NOP_ON_INVALID(1'b1)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .BUSDATA(BUSDATA),
    .STOREDATA(STOREDATA), .C_FLAG(C_FLAG),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST),
    .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT),
    .nPC_LD(nPC_LD), .PC_EN(PC_EN), .HALTED(HALTED), .state_dbg(state_dbg)
  );

  // Second instance: leaves reset halted and decodes invalid opcodes as ADD A,Im.
  td4_bus_sequencer #(.RESET_RUN(1'b0), .NOP_ON_INVALID(1'b0)) dut_h (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .BUSDATA(BUSDATA),
    .STOREDATA(h_storedata), .C_FLAG(h_c_flag),
    .nA_ST(h_a_st), .nB_ST(h_b_st), .nOUT_ST(h_out_st),
    .nA_OUT(h_a_out), .nB_OUT(h_b_out), .nIN_OUT(h_in_out),
    .nPC_LD(h_pc_ld), .PC_EN(h_pc_en), .HALTED(h_halted), .state_dbg(h_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // Bus and strobe exclusivity on the main instance, every cycle out of reset.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      tests++;
      assert ($onehot0(~{nA_OUT, nB_OUT, nIN_OUT}) && $onehot0(~{nA_ST, nB_ST, nOUT_ST, nPC_LD})) else begin
        failed++;
        $error("FAIL invariant: observed %0h expected at most one low per group", nvec);
      end
    end
  end

  initial begin
    RST = 1'b0; RUN = 1'b1; STEP = 1'b0; INSTR = 8'h35; BUSDATA = 4'h0;
    cyc();
    chk("rst_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("rst_pc_en", {7'd0, PC_EN}, 8'd0);
    chk("rst_c", {7'd0, C_FLAG}, 8'd0);
    chk("rst_halted", {7'd0, HALTED}, 8'd0);
    chk("rst_state", {6'd0, state_dbg}, {6'd0, S_FETCH});
    chk("rst_ir_zero", {4'd0, STOREDATA}, 8'h00);
    chk("rst_h_halted", {7'd0, h_halted}, 8'd1);
    chk("rst_h_state", {6'd0, h_state}, {6'd0, S_HALT});
    RST = 1'b1;

    cyc();  // EXEC of MOV A,5
    chk("mova_nvec", {1'b0, nvec}, {1'b0, V_MOVA});
    chk("mova_pc_en", {7'd0, PC_EN}, 8'd1);
    chk("mova_sd", {4'd0, STOREDATA}, 8'h05);
    chk("mova_state", {6'd0, state_dbg}, {6'd0, S_EXEC});
    chk("h_run_state", {6'd0, h_state}, {6'd0, S_FETCH});
    cyc();  // FETCH
    chk("mova_c", {7'd0, C_FLAG}, 8'd0);
    chk("fetch_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("fetch_pc_en", {7'd0, PC_EN}, 8'd0);
    INSTR = 8'h01; BUSDATA = 4'hF;

    cyc();  // EXEC of ADD A,1 with A = F
    chk("wrap_nvec", {1'b0, nvec}, {1'b0, V_ADDA});
    chk("wrap_sd", {4'd0, STOREDATA}, 8'h00);
    cyc();
    chk("wrap_c", {7'd0, C_FLAG}, 8'd1);
    INSTR = 8'hE7; BUSDATA = 4'h0;

    cyc();  // JNC 7 with carry set: not taken
    chk("jnc_nt_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("jnc_nt_pc_en", {7'd0, PC_EN}, 8'd1);
    chk("jnc_nt_sd", {4'd0, STOREDATA}, 8'h07);
    cyc();
    chk("jnc_nt_c", {7'd0, C_FLAG}, 8'd0);
    cyc();  // JNC 7 with carry clear: taken
    chk("jnc_t_nvec", {1'b0, nvec}, {1'b0, V_JMP});
    chk("jnc_t_pc_en", {7'd0, PC_EN}, 8'd0);
    chk("jnc_t_sd", {4'd0, STOREDATA}, 8'h07);
    cyc();
    INSTR = 8'hF3;
    cyc();  // JMP 3
    chk("jmp_nvec", {1'b0, nvec}, {1'b0, V_JMP});
    chk("jmp_pc_en", {7'd0, PC_EN}, 8'd0);
    chk("jmp_sd", {4'd0, STOREDATA}, 8'h03);
    cyc();
    INSTR = 8'h0F; BUSDATA = 4'h1;
    cyc();  // ADD A,F with A = 1 sets carry
    chk("addf_nvec", {1'b0, nvec}, {1'b0, V_ADDA});
    chk("addf_sd", {4'd0, STOREDATA}, 8'h00);
    cyc();
    chk("addf_c", {7'd0, C_FLAG}, 8'd1);
    INSTR = 8'h83; BUSDATA = 4'h0;

    cyc();  // opcode 8: NOP on main instance
    chk("nop_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("nop_pc_en", {7'd0, PC_EN}, 8'd1);
    chk("nop_sd", {4'd0, STOREDATA}, 8'h03);
    cyc();  // main FETCH, second instance in EXEC of the same word
    chk("nop_c", {7'd0, C_FLAG}, 8'd0);
    chk("h_inv_nvec", {1'b0, h_nvec}, {1'b0, V_ADDA});
    RUN = 1'b0; INSTR = 8'h30; BUSDATA = 4'h0;

    cyc();  // RUN dropped during FETCH: instruction still executes
    chk("rundrop_nvec", {1'b0, nvec}, {1'b0, V_MOVA});
    cyc();
    chk("halt_halted", {7'd0, HALTED}, 8'd1);
    chk("halt_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("halt_pc_en", {7'd0, PC_EN}, 8'd0);
    repeat (3) cyc();
    chk("halt_stay", {6'd0, state_dbg}, {6'd0, S_HALT});

    INSTR = 8'h90; BUSDATA = 4'hA; STEP = 1'b1;
    cyc();
    chk("step_fetch", {6'd0, state_dbg}, {6'd0, S_FETCH});
    chk("step_halted", {7'd0, HALTED}, 8'd0);
    cyc();  // OUT B
    chk("outb_nvec", {1'b0, nvec}, {1'b0, V_OUTB});
    chk("outb_sd", {4'd0, STOREDATA}, 8'h0A);
    chk("outb_pc_en", {7'd0, PC_EN}, 8'd1);
    cyc();
    chk("step_back_halt", {7'd0, HALTED}, 8'd1);
    chk("step_back_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (nvec !== V_IDLE || PC_EN !== 1'b0 || HALTED !== 1'b1) n_bad++;
    end
    chk("step_held", n_bad[7:0], 8'd0);

    STEP = 1'b0;
    cyc();
    INSTR = 8'h0F; BUSDATA = 4'h1; STEP = 1'b1;
    cyc();
    chk("step2_fetch", {7'd0, HALTED}, 8'd0);
    cyc();
    chk("step2_nvec", {1'b0, nvec}, {1'b0, V_ADDA});
    cyc();
    chk("step2_c", {7'd0, C_FLAG}, 8'd1);
    chk("step2_halted", {7'd0, HALTED}, 8'd1);
    STEP = 1'b0; RUN = 1'b1; INSTR = 8'h55; BUSDATA = 4'h2;

    cyc();
    chk("resume_state", {6'd0, state_dbg}, {6'd0, S_FETCH});
    cyc();  // EXEC of ADD B,5
    chk("addb_nvec", {1'b0, nvec}, {1'b0, V_ADDB});
    chk("addb_sd", {4'd0, STOREDATA}, 8'h07);
    #2 RST = 1'b0;
    #1;
    chk("midrst_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("midrst_pc_en", {7'd0, PC_EN}, 8'd0);
    chk("midrst_c", {7'd0, C_FLAG}, 8'd0);
    chk("midrst_ir", {4'd0, STOREDATA}, 8'h02);
    chk("midrst_state", {6'd0, state_dbg}, {6'd0, S_FETCH});
    chk("midrst_h_halted", {7'd0, h_halted}, 8'd1);
    cyc();
    chk("inrst_nvec", {1'b0, nvec}, {1'b0, V_IDLE});
    chk("inrst_c", {7'd0, C_FLAG}, 8'd0);
    RST = 1'b1;
    cyc();
    chk("release_exec", {1'b0, nvec}, {1'b0, V_ADDB});
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
